fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter N, default 16, meaning address/instruction width in bits.
REQ-002 SHALL have port Clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port PC_out  input  N  current PC from the program counter.
REQ-005 SHALL have port PC_in  output  N  next PC to the program counter, combinational.
REQ-006 SHALL have port PC_write_data  output  1  PC load enable, combinational.
REQ-007 SHALL have port imem_req  output  1  instruction memory request.
REQ-008 SHALL have port imem_addr  output  N  request address, stable while imem_req=1 and imem_ack=0.
REQ-009 SHALL have port imem_ack  input  1  response valid; sampled only while imem_req=1.
REQ-010 SHALL have port imem_rdata  input  N  instruction word, valid with imem_ack.
REQ-011 SHALL have port branch_taken  input  1  redirect request from execute.
REQ-012 SHALL have port branch_target  input  N  redirect address.
REQ-013 SHALL have port stall  input  1  decode not ready; hold IF/ID.
REQ-014 SHALL have ports IFID_instr, IFID_pc (output N) and IFID_valid (output 1), registered IF/ID contents.

Function
REQ-015 SHALL implement FSM states FETCH, HOLD, DRAIN.
REQ-016 FETCH: imem_req=1; imem_addr=PC_out on request issue, latched in req_addr until ack.
REQ-017 FETCH, ack=1, stall=0, no branch: IF/ID <= {imem_rdata, req_addr, 1}; PC_in=PC_out+1; PC_write_data=1; stay in FETCH.
REQ-018 FETCH, ack=1, stall=1: rdata and req_addr captured into skid register; IF/ID held; PC_write_data=0; next state HOLD.
REQ-019 FETCH, ack=0: PC_write_data=0; IFID_valid <= 0 if stall=0 (bubble), else IF/ID held.
REQ-020 HOLD: imem_req=0; when stall falls, IF/ID <= skid with valid=1, PC_in=PC_out+1, PC_write_data=1, next FETCH.
REQ-021 branch_taken=1 in any state SHALL override stall: PC_in=branch_target, PC_write_data=1, IFID_valid <= 0, skid discarded.
REQ-022 branch_taken with an outstanding unacked request SHALL go to DRAIN; otherwise (ack in same cycle, or HOLD) to FETCH.
REQ-023 DRAIN: imem_req=1 with req_addr held; on ack data discarded, next FETCH; a further branch in DRAIN updates PC only.
REQ-024 PC increment SHALL be modulo 2^N (0xFFFF+1 -> 0x0000); IFID_pc carries the fetched address.
REQ-025 Latency: ack at edge k presents the instruction on IF/ID after edge k when stall=0.

Reset
REQ-026 Reset SHALL force state FETCH, IFID_instr/IFID_pc/IFID_valid/req_addr/skid to 0, regardless of other inputs.
REQ-027 While Reset=1, PC_write_data=0 and imem_req=0; a request in flight at reset is abandoned.

Configuration
REQ-028 Macro FETCH_PERF_COUNT_EN defined: outputs perf_fetch_cnt (N) counting IF/ID loads and perf_bubble_cnt (N) counting cycles with IFID_valid cleared, both saturating at all-ones, reset to 0.
REQ-029 Macro undefined: counters and their ports absent; all other behaviour identical.

Structure
REQ-030 Package fetch_pkg SHALL hold width constant N, state enumeration, and PC increment constant (1).
REQ-031 Skid register SHALL be sub-module fetch_skid_buffer (load, clear, instr/pc out, valid flag).

Verification
REQ-032 Reset then PC_out=0x0000, ack every cycle, stall=0 -> IFID_pc 0x0000,0x0001,0x0002 on consecutive cycles, IFID_valid=1.
REQ-033 Ack with rdata=0xA5A5 while stall=1 for 3 cycles -> HOLD, PC_write_data=0; stall drop -> IFID_instr=0xA5A5, PC_in=PC_out+1.
REQ-034 Request to 0x0010 unacked, branch_taken to 0x0040 -> PC_in=0x0040, DRAIN; late ack data 0x1234 never reaches IF/ID.
REQ-035 PC_out=0xFFFF acked -> PC_in=0x0000, IFID_pc=0xFFFF.
REQ-036 Reset asserted in HOLD -> next cycle IFID_valid=0, imem_req=0 during reset, state FETCH after release; with FETCH_PERF_COUNT_EN counters read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: datapath width, FSM states
// and the PC increment step.
package fetch_pkg;

    localparam int N      = 16;
    localparam int PC_INC = 1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid register holding an acknowledged instruction while decode stalls.
module fetch_skid_buffer #(
    parameter int N = fetch_pkg::N
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [N-1:0] i_instr,
    input  logic [N-1:0] i_pc,
    output logic [N-1:0] o_instr,
    output logic [N-1:0] o_pc,
    output logic         o_valid
);

    logic [N-1:0] r_instr;
    logic [N-1:0] r_pc;
    logic         r_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge Clock) begin
        if (Reset || i_clear) begin
            r_instr <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC, talks to instruction memory and fills IF/ID.
// Optional macro FETCH_PERF_COUNT_EN adds saturating fetch/bubble counters.
module fetch_unit #(
    parameter int N = fetch_pkg::N
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] PC_out,
    output logic [N-1:0] PC_in,
    output logic         PC_write_data,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [N-1:0] imem_rdata,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic         stall,
    output logic [N-1:0] IFID_instr,
    output logic [N-1:0] IFID_pc,
    output logic         IFID_valid
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [N-1:0] perf_fetch_cnt,
    output logic [N-1:0] perf_bubble_cnt
`endif
);
    import fetch_pkg::*;

    state_t       r_state;
    logic         r_pending;
    logic [N-1:0] r_req_addr;
    logic [N-1:0] r_ifid_instr;
    logic [N-1:0] r_ifid_pc;
    logic         r_ifid_valid;

    logic         w_ack;
    logic         w_ifid_load;
    logic         w_ifid_from_skid;
    logic         w_ifid_bubble;
    logic         w_skid_load;
    logic         w_skid_clear;
    logic         w_skid_valid;
    logic [N-1:0] w_skid_instr;
    logic [N-1:0] w_skid_pc;

    fetch_skid_buffer #(.N(N)) u_skid (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_instr (imem_rdata),
        .i_pc    (imem_addr),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc),
        .o_valid (w_skid_valid)
    );

    // NOTE: every signal gets a default at the top of always_comb so that no
    // path through the branches below leaves it unassigned and infers a latch.
    always_comb begin
        imem_req         = !Reset && (r_state != HOLD);
        imem_addr        = r_pending ? r_req_addr : PC_out;
        w_ack            = imem_req && imem_ack;
        PC_in            = PC_out + N'(PC_INC);
        PC_write_data    = 1'b0;
        w_ifid_load      = 1'b0;
        w_ifid_from_skid = 1'b0;
        w_ifid_bubble    = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (Reset) begin
            PC_write_data = 1'b0;
        end else if (branch_taken) begin
            // A redirect wins over stall and throws away anything fetched so far.
            PC_in         = branch_target;
            PC_write_data = 1'b1;
            w_ifid_bubble = 1'b1;
            w_skid_clear  = 1'b1;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_ack && stall) begin
                        w_skid_load = 1'b1;
                    end else if (w_ack) begin
                        w_ifid_load   = 1'b1;
                        PC_write_data = 1'b1;
                    end else if (!stall) begin
                        w_ifid_bubble = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall && w_skid_valid) begin
                        w_ifid_load      = 1'b1;
                        w_ifid_from_skid = 1'b1;
                        PC_write_data    = 1'b1;
                        w_skid_clear     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state      <= FETCH;
            r_pending    <= 1'b0;
            r_req_addr   <= '0;
            r_ifid_instr <= '0;
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
        end else begin
            if (w_ifid_load) begin
                r_ifid_instr <= w_ifid_from_skid ? w_skid_instr : imem_rdata;
                r_ifid_pc    <= w_ifid_from_skid ? w_skid_pc : imem_addr;
                r_ifid_valid <= 1'b1;
            end else if (w_ifid_bubble) begin
                r_ifid_valid <= 1'b0;
            end
            case (r_state)
                FETCH: begin
                    // Keep the issued address stable until memory acknowledges it.
                    if (w_ack) begin
                        r_pending <= 1'b0;
                    end else begin
                        r_pending  <= 1'b1;
                        r_req_addr <= imem_addr;
                    end
                    if (branch_taken) begin
                        r_state <= w_ack ? FETCH : DRAIN;
                    end else if (w_ack && stall) begin
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (branch_taken || !stall) begin
                        r_state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (w_ack) begin
                        r_pending <= 1'b0;
                        r_state   <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    assign IFID_instr = r_ifid_instr;
    assign IFID_pc    = r_ifid_pc;
    assign IFID_valid = r_ifid_valid;

`ifdef FETCH_PERF_COUNT_EN
    logic [N-1:0] r_perf_fetch;
    logic [N-1:0] r_perf_bubble;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_perf_fetch  <= '0;
            r_perf_bubble <= '0;
        end else begin
            if (w_ifid_load && (r_perf_fetch != '1)) begin
                r_perf_fetch <= r_perf_fetch + 1'b1;
            end
            if (w_ifid_bubble && (r_perf_bubble != '1)) begin
                r_perf_bubble <= r_perf_bubble + 1'b1;
            end
        end
    end

    assign perf_fetch_cnt  = r_perf_fetch;
    assign perf_bubble_cnt = r_perf_bubble;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// compared against a behavioural model of the fetch rules.
module tb_fetch_unit;

    localparam int N = 16;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic [N-1:0] PC_out = '0;
    logic [N-1:0] PC_in;
    logic         PC_write_data;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ack = 1'b0;
    logic [N-1:0] imem_rdata = '0;
    logic         branch_taken = 1'b0;
    logic [N-1:0] branch_target = '0;
    logic         stall = 1'b0;
    logic [N-1:0] IFID_instr;
    logic [N-1:0] IFID_pc;
    logic         IFID_valid;
`ifdef FETCH_PERF_COUNT_EN
    logic [N-1:0] perf_fetch_cnt;
    logic [N-1:0] perf_bubble_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: program counter, IF/ID, a parked instruction while
    // decode stalls, and an unanswered request that must be drained or waited on.
    logic [N-1:0] m_pc, m_ifid_instr, m_ifid_pc, m_held_instr, m_held_pc, m_out_addr;
    bit           m_ifid_valid, m_held, m_draining, m_has_out;
    int           m_fetch_cnt, m_bubble_cnt;

    logic [N-1:0] obs_pc_in, obs_addr;
    logic         obs_we, obs_req;

    always #5 Clock = ~Clock;

    fetch_unit #(.N(N)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .PC_out        (PC_out),
        .PC_in         (PC_in),
        .PC_write_data (PC_write_data),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .IFID_instr    (IFID_instr),
        .IFID_pc       (IFID_pc),
        .IFID_valid    (IFID_valid)
`ifdef FETCH_PERF_COUNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int cnt);
        return (cnt > 65535) ? 32'd65535 : 32'(cnt);
    endfunction

    task automatic model_reset();
        m_pc         = '0;
        m_ifid_instr = '0;
        m_ifid_pc    = '0;
        m_ifid_valid = 1'b0;
        m_held       = 1'b0;
        m_held_instr = '0;
        m_held_pc    = '0;
        m_draining   = 1'b0;
        m_has_out    = 1'b0;
        m_out_addr   = '0;
        m_fetch_cnt  = 0;
        m_bubble_cnt = 0;
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clock);
            Reset         = 1'b1;
            PC_out        = N'($urandom);
            imem_ack      = 1'($urandom);
            imem_rdata    = N'($urandom);
            branch_taken  = 1'($urandom);
            branch_target = N'($urandom);
            stall         = 1'($urandom);
            #1;
            check("rst_pc_we", PC_write_data, 0);
            check("rst_imem_req", imem_req, 0);
            @(posedge Clock);
            #1;
            model_reset();
            check("rst_ifid_valid", IFID_valid, 0);
            check("rst_ifid_pc", IFID_pc, 0);
            check("rst_ifid_instr", IFID_instr, 0);
`ifdef FETCH_PERF_COUNT_EN
            check("rst_perf_fetch", perf_fetch_cnt, 0);
            check("rst_perf_bubble", perf_bubble_cnt, 0);
`endif
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit ack, input logic [N-1:0] rdata, input bit br,
                        input logic [N-1:0] tgt, input bit st);
        bit           req, acked, we;
        logic [N-1:0] addr, pin;
        @(negedge Clock);
        Reset         = 1'b0;
        PC_out        = m_pc;
        imem_ack      = ack;
        imem_rdata    = rdata;
        branch_taken  = br;
        branch_target = tgt;
        stall         = st;
        #1;
        check("ifid_valid", IFID_valid, m_ifid_valid);
        check("ifid_instr", IFID_instr, m_ifid_instr);
        check("ifid_pc", IFID_pc, m_ifid_pc);
`ifdef FETCH_PERF_COUNT_EN
        check("perf_fetch", perf_fetch_cnt, sat(m_fetch_cnt));
        check("perf_bubble", perf_bubble_cnt, sat(m_bubble_cnt));
`endif
        req   = !m_held;
        addr  = m_has_out ? m_out_addr : m_pc;
        acked = req && ack;
        we    = 1'b0;
        pin   = m_pc + 1'b1;
        if (br) begin
            we           = 1'b1;
            pin          = tgt;
            m_ifid_valid = 1'b0;
            m_bubble_cnt++;
            m_held       = 1'b0;
            if (m_draining) begin
                if (acked) begin
                    m_draining = 1'b0;
                    m_has_out  = 1'b0;
                end
            end else if (req && !acked) begin
                m_draining = 1'b1;
                m_has_out  = 1'b1;
                m_out_addr = addr;
            end else begin
                m_has_out = 1'b0;
            end
        end else if (m_draining) begin
            if (acked) begin
                m_draining = 1'b0;
                m_has_out  = 1'b0;
            end
        end else if (m_held) begin
            if (!st) begin
                we           = 1'b1;
                m_ifid_instr = m_held_instr;
                m_ifid_pc    = m_held_pc;
                m_ifid_valid = 1'b1;
                m_fetch_cnt++;
                m_held       = 1'b0;
            end
        end else if (acked) begin
            m_has_out = 1'b0;
            if (st) begin
                m_held       = 1'b1;
                m_held_instr = rdata;
                m_held_pc    = addr;
            end else begin
                we           = 1'b1;
                m_ifid_instr = rdata;
                m_ifid_pc    = addr;
                m_ifid_valid = 1'b1;
                m_fetch_cnt++;
            end
        end else begin
            m_has_out  = 1'b1;
            m_out_addr = addr;
            if (!st) begin
                m_ifid_valid = 1'b0;
                m_bubble_cnt++;
            end
        end
        check("imem_req", imem_req, req);
        if (req) check("imem_addr", imem_addr, addr);
        check("pc_we", PC_write_data, we);
        if (we) check("pc_in", PC_in, pin);
        obs_pc_in = PC_in;
        obs_addr  = imem_addr;
        obs_we    = PC_write_data;
        obs_req   = imem_req;
        if (we) m_pc = pin;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        model_reset();
        do_reset(2);

        // Back-to-back fetch from address 0.
        step(1'b1, 16'h1111, 1'b0, '0, 1'b0);
        check("seq_pc0", IFID_pc, 16'h0000);
        check("seq_valid0", IFID_valid, 1);
        step(1'b1, 16'h2222, 1'b0, '0, 1'b0);
        check("seq_pc1", IFID_pc, 16'h0001);
        step(1'b1, 16'h3333, 1'b0, '0, 1'b0);
        check("seq_pc2", IFID_pc, 16'h0002);
        check("seq_instr2", IFID_instr, 16'h3333);

        // Wrap of the PC at the top of the address space.
        m_pc = 16'hFFFF;
        step(1'b1, 16'hBEEF, 1'b0, '0, 1'b0);
        check("wrap_pc_in", obs_pc_in, 16'h0000);
        check("wrap_ifid_pc", IFID_pc, 16'hFFFF);

        // Ack under stall parks the word until decode is ready.
        step(1'b1, 16'hA5A5, 1'b0, '0, 1'b1);
        check("hold_enter_we", obs_we, 0);
        step(1'b1, 16'h0BAD, 1'b0, '0, 1'b1);
        check("hold_req", obs_req, 0);
        check("hold_we", obs_we, 0);
        step(1'b0, 16'h0BAD, 1'b0, '0, 1'b1);
        check("hold_req2", obs_req, 0);
        step(1'b0, 16'h0BAD, 1'b0, '0, 1'b0);
        check("hold_release_we", obs_we, 1);
        check("hold_release_pc_in", obs_pc_in, 16'h0001);
        check("hold_release_instr", IFID_instr, 16'hA5A5);
        check("hold_release_pc", IFID_pc, 16'h0000);

        // Branch while a request is unanswered: late data must be dropped.
        m_pc = 16'h0010;
        step(1'b0, 16'h0000, 1'b0, '0, 1'b0);
        check("drain_issue_addr", obs_addr, 16'h0010);
        step(1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0);
        check("drain_branch_pc_in", obs_pc_in, 16'h0040);
        check("drain_branch_we", obs_we, 1);
        step(1'b0, 16'h0000, 1'b0, '0, 1'b0);
        check("drain_addr_held", obs_addr, 16'h0010);
        step(1'b1, 16'h1234, 1'b0, '0, 1'b0);
        check("drain_ack_addr", obs_addr, 16'h0010);
        check("drain_discard_valid", IFID_valid, 0);
        step(1'b1, 16'h5678, 1'b0, '0, 1'b0);
        check("after_drain_addr", obs_addr, 16'h0040);
        check("after_drain_instr", IFID_instr, 16'h5678);
        check("after_drain_pc", IFID_pc, 16'h0040);

        // Reset while holding a parked instruction.
        step(1'b1, 16'hC0DE, 1'b0, '0, 1'b1);
        do_reset(1);
        step(1'b0, 16'h0000, 1'b0, '0, 1'b1);
        check("post_rst_req", obs_req, 1);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset(1);
            end else begin
                step($urandom_range(99) < 60, N'($urandom), $urandom_range(99) < 8,
                     N'($urandom), $urandom_range(99) < 30);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
